// File: rtl/lcd_frame_scheduler.sv
// Pixel-slot timing generator for the LVDS LCD path: walks (h,v) once per CLK_DIV clocks,
// pulls RGB666 pixels on active slots and registers HS/VS/DE/RGB for the 7:1 serializer.
module lcd_frame_scheduler #(
  parameter int CLK_DIV  = 7,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [17:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        underflow_clr,
  output logic [17:0] out_rgb,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic        word_load,
  output logic        frame_start,
  output logic        underflow,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  // Boundaries carry one extra bit so a zero back porch cannot overflow them.
  localparam logic [HW:0] H_ACT  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [DW-1:0] d;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [DW-1:0] drain_cnt;
  logic          draining;

  logic tick;
  logic active;
  logic last_slot;
  logic stop;
  logic [HW:0] h_x;
  logic [VW:0] v_x;

  assign h_x       = {1'b0, h};
  assign v_x       = {1'b0, v};
  assign tick      = (state == RUN) && (d == D_LAST);
  assign active    = (h_x < H_ACT) && (v_x < V_ACT);
  assign last_slot = (h == H_LAST) && (v == V_LAST);
  assign stop      = tick && last_slot && !enable;
  assign busy      = (state == RUN);

  // Handshake: a pixel transfers in a cycle where pix_valid && pix_ready. pix_ready is
  // high only on the tick cycle of an active slot, so blanking never consumes data and
  // a waiting source simply holds pix_data/pix_valid until the next active tick.
  assign pix_ready = tick && active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      d     <= '0;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        IDLE: begin
          d <= '0;
          h <= '0;
          v <= '0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (tick) begin
            d <= '0;
            if (h == H_LAST) begin
              h <= '0;
              v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
              h <= h + 1'b1;
            end
            if (stop) state <= IDLE;
          end else begin
            d <= d + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The last slot of a stopped frame stays on the wires for a full slot before clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_rgb     <= '0;
      out_hs      <= 1'b0;
      out_vs      <= 1'b0;
      out_de      <= 1'b0;
      word_load   <= 1'b0;
      frame_start <= 1'b0;
      draining    <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      word_load   <= tick;
      frame_start <= tick && (h == '0) && (v == '0);
      if (tick) begin
        out_rgb   <= (active && pix_valid) ? pix_data : '0;
        out_de    <= active;
        out_hs    <= (h_x >= HS_BEG) && (h_x < HS_END);
        out_vs    <= (v_x >= VS_BEG) && (v_x < VS_END);
        draining  <= stop;
        drain_cnt <= '0;
      end else if (draining) begin
        if (drain_cnt == D_LAST) begin
          out_rgb  <= '0;
          out_de   <= 1'b0;
          out_hs   <= 1'b0;
          out_vs   <= 1'b0;
          draining <= 1'b0;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (tick && active && !pix_valid) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Randomized bench for lcd_frame_scheduler, compared against a slot-index model of the
// raster (slot = cycle / CLK_DIV, position = slot mod frame size).
module tb_lcd_frame_scheduler;

  localparam int CLK_DIV  = 3;
  localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 1, H_BP = 1;
  localparam int V_ACTIVE = 2, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SLOTS    = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [17:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        underflow_clr;
  logic [17:0] out_rgb;
  logic        out_hs, out_vs, out_de;
  logic        word_load, frame_start, underflow, busy;

  lcd_frame_scheduler #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .underflow_clr(underflow_clr), .out_rgb(out_rgb),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .word_load(word_load),
    .frame_start(frame_start), .underflow(underflow), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  bit          m_run;
  int          m_c;
  int          m_drain;
  logic [17:0] m_rgb;
  bit          m_hs, m_vs, m_de, m_wl, m_fs, m_uf;
  logic [17:0] pix_next;
  logic [17:0] exp_q[$];

  // observation counters
  int  wl_cnt, fs_cnt, take_cnt, dbl_ready;
  bit  last_fs, prev_ready;

  function automatic int cur_slot();
    return m_run ? (m_c / CLK_DIV) % SLOTS : -1;
  endfunction

  function automatic bit cur_tick();
    return m_run && ((m_c % CLK_DIV) == CLK_DIV - 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_c = 0; m_drain = 0; m_rgb = '0;
    m_hs = 0; m_vs = 0; m_de = 0; m_wl = 0; m_fs = 0; m_uf = 0;
    exp_q.delete();
    prev_ready = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb"}, 32'(out_rgb), 0);
    check({tag, "_hs"}, 32'(out_hs), 0);
    check({tag, "_vs"}, 32'(out_vs), 0);
    check({tag, "_de"}, 32'(out_de), 0);
    check({tag, "_wl"}, 32'(word_load), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_uf"}, 32'(underflow), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ready"}, 32'(pix_ready), 0);
  endtask

  // driver: one clock cycle with the given inputs, model advanced alongside
  task automatic step(input bit en, input bit val, input bit clr);
    bit tick, act, stop;
    int slot, h, v;
    enable = en; pix_valid = val; underflow_clr = clr; pix_data = pix_next;
    #1;
    tick = cur_tick(); slot = cur_slot(); act = 0; stop = 0; h = 0; v = 0;
    if (m_run) begin
      h = slot % H_TOTAL;
      v = slot / H_TOTAL;
      act = (h < H_ACTIVE) && (v < V_ACTIVE);
    end
    check("pix_ready", 32'(pix_ready), 32'(tick && act));
    if (pix_ready && prev_ready) dbl_ready++;
    prev_ready = pix_ready;
    if (pix_ready && pix_valid) take_cnt++;

    m_wl = tick;
    m_fs = tick && (slot == 0);
    if (tick) begin
      m_de  = act;
      m_hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
      m_vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
      m_rgb = (act && val) ? pix_next : 18'd0;
      exp_q.push_back(m_rgb);
      if (act && val) pix_next = pix_next + 18'd1;
      stop = (slot == SLOTS - 1) && !en;
      if (stop) m_drain = CLK_DIV;
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin
        m_rgb = '0; m_hs = 0; m_vs = 0; m_de = 0;
      end
    end
    if (tick && act && !val) m_uf = 1;
    else if (clr) m_uf = 0;
    if (m_run) begin
      if (stop) m_run = 0;
      else m_c++;
    end else if (en) begin
      m_run = 1;
      m_c = 0;
    end

    @(posedge clk);
    #1;
    check("out_rgb", 32'(out_rgb), 32'(m_rgb));
    check("out_hs", 32'(out_hs), 32'(m_hs));
    check("out_vs", 32'(out_vs), 32'(m_vs));
    check("out_de", 32'(out_de), 32'(m_de));
    check("word_load", 32'(word_load), 32'(m_wl));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("underflow", 32'(underflow), 32'(m_uf));
    check("busy", 32'(busy), 32'(m_run));
    if (word_load) begin
      wl_cnt++;
      if (exp_q.size() > 0) check("rgb_order", 32'(out_rgb), 32'(exp_q.pop_front()));
      else check("rgb_order_empty", 32'(1), 32'(0));
    end
    last_fs = frame_start;
    if (frame_start) fs_cnt++;
  endtask

  task automatic wait_fs(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      step(1, 1, 0);
      n++;
    end while (!last_fs && n < limit);
    if (!last_fs) check({tag, "_timeout"}, 32'(n), 32'(limit + 1));
  endtask

  initial begin
    int n;
    bit dropped;
    rst = 1'b1; enable = 0; pix_valid = 0; pix_data = '0; underflow_clr = 0;
    pix_next = 18'($urandom);
    model_reset();
    wl_cnt = 0; fs_cnt = 0; take_cnt = 0; dbl_ready = 0; last_fs = 0;
    #2;
    check_all_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // idle with enable low
    wl_cnt = 0;
    repeat (20) step(0, $urandom_range(0, 1), 0);
    check("idle_wl_count", 32'(wl_cnt), 0);

    // steady streaming, valid held through blanking
    wait_fs("first_fs", 10);
    wl_cnt = 0; fs_cnt = 0; take_cnt = 0;
    repeat (3 * SLOTS * CLK_DIV) step(1, 1, 0);
    check("stream_wl_count", 32'(wl_cnt), 32'(3 * SLOTS));
    check("stream_fs_count", 32'(fs_cnt), 3);
    check("stream_takes", 32'(take_cnt), 32'(3 * H_ACTIVE * V_ACTIVE));

    // starvation at (2,1) with a coincident clear, then a lone clear
    for (int i = 0; i < SLOTS * CLK_DIV; i++) begin
      n = cur_slot();
      step(1, n != H_TOTAL + 2, (n == H_TOTAL + 2) && cur_tick());
    end
    check("uf_set_wins", 32'(underflow), 1);
    step(1, 1, 1);
    check("uf_cleared", 32'(underflow), 0);

    // drop enable mid-frame: frame must run to its last slot
    wait_fs("stop_fs", SLOTS * CLK_DIV + 5);
    wl_cnt = 1;
    dropped = 0;
    n = 0;
    while (m_run && n < 2 * SLOTS * CLK_DIV) begin
      if (cur_slot() >= 17) dropped = 1;
      step(!dropped, 1, 0);
      n++;
    end
    repeat (10) step(0, 1, 0);
    check("stop_wl_count", 32'(wl_cnt), 32'(SLOTS));
    check("stop_busy", 32'(busy), 0);
    check("stop_de", 32'(out_de), 0);
    check("stop_rgb", 32'(out_rgb), 0);

    // reset during the active line of frame 1
    wait_fs("rst_fs0", 10);
    wait_fs("rst_fs1", SLOTS * CLK_DIV + 5);
    repeat (7) step(1, 1, 0);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    rst = 1'b0;
    n = 0;
    do begin
      step(1, 1, 0);
      n++;
    end while (!last_fs && n < 20);
    check("rst_first_fs_edges", 32'(n), 32'(CLK_DIV + 1));

    // random valid and clear traffic
    repeat (2 * SLOTS * CLK_DIV)
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    check("ready_back_to_back", 32'(dbl_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_frame_scheduler.md
# lcd_frame_scheduler

Sequences pixel data into the LVDS LCD output path. Generates horizontal/vertical timing (HS, VS, DE) and a pixel-rate load strobe for the 3-channel 7:1 serializer that drives channel1..3 and the LVDS clock pair. Pulls RGB666 pixels from an upstream source over a valid/ready handshake and substitutes black on starvation. Sits between the pixel source and the serializer inside `maincore`.

## Interface
- CLK_DIV, 7: system clocks per pixel slot (≥2)
- H_ACTIVE, 800; H_FP, 40; H_SYNC, 48; H_BP, 40: horizontal pixels; H_TOTAL = sum
- V_ACTIVE, 480; V_FP, 13; V_SYNC, 3; V_BP, 32: vertical lines; V_TOTAL = sum
- clk  in  1  system clock (CLK100MHZ domain)
- rst  in  1  asynchronous reset, active-high
- enable  in  1  run request; sampled at frame boundaries
- pix_data  in  18  RGB666 {R[5:0],G[5:0],B[5:0]}
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  pixel consumed this cycle when pix_valid also high
- underflow_clr  in  1  clears underflow
- out_rgb  out  18  pixel to serializer
- out_hs, out_vs, out_de  out  1  sync/enable, active-high
- word_load  out  1  one-cycle strobe: out_* hold new slot values
- frame_start  out  1  coincident with word_load of slot (0,0)
- underflow  out  1  sticky: active slot had no pixel
- busy  out  1  state is RUN

## Operation
- States: IDLE, RUN.
- IDLE: counters d=h=v=0; out_* and strobes 0; busy 0. enable=1 -> RUN next edge.
- RUN: d counts 0..CLK_DIV-1, wraps. Slot tick when d==CLK_DIV-1.
- On tick: position (h,v) emitted. active = h<H_ACTIVE && v<V_ACTIVE. pix_ready = tick && active (combinational). out_rgb <= (active && pix_valid) ? pix_data : 0; out_de <= active; out_hs <= h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); out_vs <= v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Underflow: tick && active && !pix_valid sets underflow; out_de still 1, out_rgb 0. underflow_clr clears; set wins when simultaneous.
- Advance on tick: h wraps at H_TOTAL-1 to 0 and increments v; v wraps at V_TOTAL-1 to 0.
- Stop: enable sampled only on tick at (H_TOTAL-1, V_TOTAL-1). If 0 there, slot is still emitted, then RUN -> IDLE; out_* cleared on next tick-equivalent edge (CLK_DIV cycles later). Frames are never truncated.
- No pixel consumed outside pix_ready; pix_valid during blanking is ignored and held.
- Reset mid-operation: all registers to reset values immediately; next frame starts from (0,0).

## Timing
- Reset values: every output 0; state IDLE; underflow 0.
- Entering RUN at edge E: d=0 after E; first tick in cycle E+CLK_DIV-1; out_* for (0,0) valid from next edge; word_load and frame_start high that one cycle.
- word_load: registered copy of tick, so it coincides with the first cycle of new out_* values; period exactly CLK_DIV cycles in RUN, no gaps across line/frame wrap.
- out_* stable for CLK_DIV cycles between updates.
- Frame period in RUN: H_TOTAL·V_TOTAL·CLK_DIV cycles.
- Back-to-back frames: with enable held 1, slot (0,0) of frame N+1 follows slot (H_TOTAL-1,V_TOTAL-1) by one slot.
- pix_ready is never high two consecutive cycles.

## Test plan
Bench params: CLK_DIV=3; H 4/1/1/1 (H_TOTAL=7); V 2/1/1/1 (V_TOTAL=5).
- Reset then idle 20 cycles -> all outputs 0, word_load never pulses.
- enable=1, pix_valid=1 with incrementing pix_data -> word_load every 3 cycles; frame_start every 105 cycles; out_de high for slots h0-3 of lines 0-1 only (8 per frame); out_hs at h=5; out_vs on v=3; out_rgb 0 in blanking; 8 pixels consumed per frame, in order.
- pix_valid=0 at active slot (h=2,v=1) -> out_rgb=0, out_de=1, underflow=1 sticky; pulse underflow_clr -> 0; clr coincident with new underflow -> stays 1.
- Drop enable mid-frame -> frame completes to slot (6,4), then busy=0 and outputs 0; total word_loads for that frame exactly 35.
- Assert rst during active line of frame 1 -> outputs 0 asynchronously; on release with enable=1, first frame_start after exactly 3 cycles of RUN.
- pix_valid=1 held through blanking -> pix_ready low in all blanking slots, no data consumed.
